// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads words into the IR and hands them to control.
// Define IFU_PREFETCH_EN to add a one-entry prefetch buffer that fetches ahead while in HOLD.
//
// state | meaning
// FETCH | read request at pc, waiting for mem_ack
// HOLD  | ir valid, waiting for ir_ready (prefetch build: fills pf_buf meanwhile)
// DRAIN | prefetch build only: wait out an abandoned request, returned data dropped
module instr_fetch_unit #(
    parameter int unsigned     PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            mem_rd,
    output logic [PC_W-1:0] mem_addr,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_ack,
    output logic [31:0]     ir,
    output logic [PC_W-1:0] ir_pc,
    output logic            ir_valid,
    input  logic            ir_ready,
    input  logic            pc_load,
    input  logic [PC_W-1:0] pc_in,
    output logic [31:0]     retired
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
    localparam logic [PC_W-1:0] WORD_STEP  = PC_W'(4);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [PC_W-1:0] ir_pc_q, ir_pc_d;
    logic [31:0]     retired_q, retired_d;
    logic [PC_W-1:0] pc_word;
    logic [PC_W-1:0] target;

`ifdef IFU_PREFETCH_EN
    logic [31:0]     pf_buf_q, pf_buf_d;
    logic            pf_valid_q, pf_valid_d;
    logic [PC_W-1:0] drain_addr_q, drain_addr_d;
`endif

    assign pc_word = pc_q & ALIGN_MASK;
    assign target  = pc_in & ALIGN_MASK;
    assign ir      = ir_q;
    assign ir_pc   = ir_pc_q;
    assign retired = retired_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            ir_pc_q   <= '0;
            retired_q <= '0;
`ifdef IFU_PREFETCH_EN
            pf_buf_q     <= '0;
            pf_valid_q   <= 1'b0;
            drain_addr_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            ir_pc_q   <= ir_pc_d;
            retired_q <= retired_d;
`ifdef IFU_PREFETCH_EN
            pf_buf_q     <= pf_buf_d;
            pf_valid_q   <= pf_valid_d;
            drain_addr_q <= drain_addr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        ir_pc_d   = ir_pc_q;
        retired_d = retired_q;
        mem_rd    = 1'b0;
        mem_addr  = pc_word;
        ir_valid  = 1'b0;
`ifdef IFU_PREFETCH_EN
        pf_buf_d     = pf_buf_q;
        pf_valid_d   = pf_valid_q;
        drain_addr_d = drain_addr_q;
`endif

        case (state_q)
            ST_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    ir_pc_d = pc_word;
                    pc_d    = pc_word + WORD_STEP;
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                ir_valid = 1'b1;
`ifdef IFU_PREFETCH_EN
                mem_rd = ~pf_valid_q;
                if (ir_ready) begin
                    retired_d = retired_q + 32'd1;
                    if (pc_load) begin
                        // Any ack this cycle belongs to the wrong path and is dropped.
                        pc_d       = target;
                        pf_valid_d = 1'b0;
                        if (!pf_valid_q && !mem_ack) begin
                            drain_addr_d = pc_word;
                            state_d      = ST_DRAIN;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else if (pf_valid_q) begin
                        ir_d       = pf_buf_q;
                        ir_pc_d    = pc_word - WORD_STEP;
                        pf_valid_d = 1'b0;
                    end else if (mem_ack) begin
                        ir_d    = mem_rdata;
                        ir_pc_d = pc_word;
                        pc_d    = pc_word + WORD_STEP;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else if (!pf_valid_q && mem_ack) begin
                    pf_buf_d   = mem_rdata;
                    pf_valid_d = 1'b1;
                    pc_d       = pc_word + WORD_STEP;
                end
`else
                if (ir_ready) begin
                    retired_d = retired_q + 32'd1;
                    if (pc_load) begin
                        pc_d = target;
                    end
                    state_d = ST_FETCH;
                end
`endif
            end

`ifdef IFU_PREFETCH_EN
            ST_DRAIN: begin
                mem_rd   = 1'b1;
                mem_addr = drain_addr_q;
                if (mem_ack) begin
                    state_d = ST_FETCH;
                end
            end
`endif

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus queues expected fetch addresses and IR contents,
// a memory model and an IR monitor pop and compare them. Prefetch scenario runs when IFU_PREFETCH_EN is set.
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset;
    logic        mem_rd;
    logic [63:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] ir;
    logic [63:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        pc_load;
    logic [63:0] pc_in;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    int wait_cnt = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] word;
    } exp_ir_t;

    exp_ir_t     exp_ir[$];
    logic [63:0] exp_addr[$];

    logic prev_valid;
    logic prev_retire;

    instr_fetch_unit #(
        .PC_W    (64),
        .RESET_PC(64'h0)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .ir       (ir),
        .ir_pc    (ir_pc),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .pc_load  (pc_load),
        .pc_in    (pc_in),
        .retired  (retired)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'h8B020020;
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic push_fetch(input logic [63:0] a, input logic [31:0] w);
        exp_addr.push_back(a);
        exp_ir.push_back({a, w});
    endtask

    // Memory model: acks after ack_delay waiting cycles, checks the address against the scoreboard.
    always @(negedge clock) begin
        if (reset || mem_rd !== 1'b1) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word(mem_addr);
            wait_cnt  = 0;
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fetch_addr: unexpected acked read at %h, none expected", mem_addr);
            end else begin
                chk("fetch_addr", mem_addr, exp_addr.pop_front());
            end
        end else begin
            mem_ack = 1'b0;
            wait_cnt++;
        end
    end

    // IR monitor: a new instruction is presented when ir_valid rises or right after a retire.
    always @(negedge clock) begin
        if (reset) begin
            prev_valid  = 1'b0;
            prev_retire = 1'b0;
        end else begin
            if (ir_valid === 1'b1 && (!prev_valid || prev_retire)) begin
                if (exp_ir.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ir_event: unexpected instruction ir=%h ir_pc=%h, none expected", ir, ir_pc);
                end else begin
                    exp_ir_t e;
                    e = exp_ir.pop_front();
                    chk("ir", 64'(ir), 64'(e.word));
                    chk("ir_pc", ir_pc, e.pc);
                end
            end
            prev_valid  = (ir_valid === 1'b1);
            prev_retire = (ir_valid === 1'b1) && (ir_ready === 1'b1);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (ir_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (ir_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: ir_valid=%b after %0d cycles, required 1", ir_valid, n);
        end
    endtask

    task automatic retire(input logic load, input logic [63:0] tgt);
        wait_valid();
        ir_ready = 1'b1;
        pc_load  = load;
        pc_in    = tgt;
        step();
        ir_ready = 1'b0;
        pc_load  = 1'b0;
        pc_in    = '0;
    endtask

`ifdef IFU_PREFETCH_EN
    logic [10:0] pf_rdy;
`endif

    initial begin
        reset     = 1'b1;
        ir_ready  = 1'b0;
        pc_load   = 1'b0;
        pc_in     = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (3) step();

        push_fetch(64'h0, 32'h8B020020);
`ifdef IFU_PREFETCH_EN
        exp_addr.push_back(64'h4);
        for (int a = 4; a <= 32; a += 4) exp_ir.push_back({64'(a), 16'hC0DE, 16'(a)});
        for (int a = 8; a <= 36; a += 4) exp_addr.push_back(64'(a));
        push_fetch(64'h80, 32'hC0DE0080);
        exp_addr.push_back(64'h84);
`endif
        reset = 1'b0;

        @(negedge clock);
        chk("rst_mem_rd", 64'(mem_rd), 64'd1);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_ir_valid", 64'(ir_valid), 64'd0);
        chk("rst_ir", 64'(ir), 64'h0);
        chk("rst_ir_pc", ir_pc, 64'h0);
        chk("rst_retired", 64'(retired), 64'd0);

`ifndef IFU_PREFETCH_EN
        step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("hold_ir", 64'(ir), 64'h8B020020);
            chk("hold_ir_pc", ir_pc, 64'h0);
            chk("hold_ir_valid", 64'(ir_valid), 64'd1);
            chk("hold_mem_rd", 64'(mem_rd), 64'd0);
            step();
        end

        push_fetch(64'h4, 32'hC0DE0004);
        retire(1'b0, 64'h0);
        @(negedge clock);
        chk("retired_1", 64'(retired), 64'd1);
        wait_valid();

        ack_delay = 3;
        push_fetch(64'h8, 32'hC0DE0008);
        retire(1'b0, 64'h0);
        for (int w = 0; w < 4; w++) begin
            if (w == 1) begin
                ir_ready = 1'b1;
                pc_load  = 1'b1;
                pc_in    = 64'h100;
            end else begin
                ir_ready = 1'b0;
                pc_load  = 1'b0;
                pc_in    = '0;
            end
            @(negedge clock);
            chk("slow_mem_rd", 64'(mem_rd), 64'd1);
            chk("slow_mem_addr", mem_addr, 64'h8);
            chk("slow_ir_valid", 64'(ir_valid), 64'd0);
            step();
        end
        ir_ready = 1'b0;
        pc_load  = 1'b0;
        pc_in    = '0;
        @(negedge clock);
        chk("slow_ir_valid_after", 64'(ir_valid), 64'd1);
        chk("retired_2", 64'(retired), 64'd2);
        ack_delay = 0;

        push_fetch(64'hC, 32'hC0DE000C);
        retire(1'b0, 64'h0);
        push_fetch(64'h10, 32'hC0DE0010);
        retire(1'b0, 64'h0);
        push_fetch(64'h40, 32'hC0DE0040);
        retire(1'b1, 64'h43);
        @(negedge clock);
        chk("branch_mem_rd", 64'(mem_rd), 64'd1);
        chk("branch_mem_addr", mem_addr, 64'h40);
        chk("retired_5", 64'(retired), 64'd5);
        wait_valid();
`else
        pf_rdy = 11'b10111101110;
        for (int i = 0; i < 11; i++) begin
            step();
            ir_ready = pf_rdy[i];
            if (i == 10) ack_delay = 2;
            @(negedge clock);
            chk("pf_ir_valid", 64'(ir_valid), 64'd1);
        end
        step();
        ir_ready = 1'b1;
        pc_load  = 1'b1;
        pc_in    = 64'h80;
        @(negedge clock);
        chk("pf_br_mem_rd", 64'(mem_rd), 64'd1);
        chk("pf_br_mem_addr", mem_addr, 64'h24);
        step();
        ir_ready = 1'b0;
        pc_load  = 1'b0;
        pc_in    = '0;
        for (int d = 0; d < 2; d++) begin
            @(negedge clock);
            chk("drain_mem_rd", 64'(mem_rd), 64'd1);
            chk("drain_mem_addr", mem_addr, 64'h24);
            chk("drain_ir_valid", 64'(ir_valid), 64'd0);
            step();
        end
        ack_delay = 0;
        @(negedge clock);
        chk("target_mem_addr", mem_addr, 64'h80);
        chk("target_mem_rd", 64'(mem_rd), 64'd1);
        step();
        @(negedge clock);
        chk("target_ir_valid", 64'(ir_valid), 64'd1);
        chk("pf_retired", 64'(retired), 64'd9);
`endif

        repeat (3) step();
        chk("exp_ir_left", 64'(exp_ir.size()), 64'd0);
        chk("exp_addr_left", 64'(exp_addr.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end for the multicycle LEGv8 datapath. It owns the program counter and issues word reads to instruction memory. It latches the returned word into the instruction register and presents it to the control unit with a valid/ready handshake. When the control unit retires the instruction, the block advances sequentially or redirects to a branch target.

## Interface
Parameters:
- PC_W, 64, program counter width in bits
- RESET_PC, 64'h0, PC value loaded on reset

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- mem_rd  output  1  instruction read request, held high until acknowledged
- mem_addr  output  PC_W  word-aligned fetch address, {pc[PC_W-1:2],2'b00}
- mem_rdata  input  32  instruction word, valid when mem_ack=1
- mem_ack  input  1  read completion, sampled only while mem_rd=1
- ir  output  32  current instruction register
- ir_pc  output  PC_W  address of the instruction in ir
- ir_valid  output  1  ir holds an instruction not yet retired
- ir_ready  input  1  control unit retires the current instruction this cycle
- pc_load  input  1  redirect; sampled only when ir_valid & ir_ready
- pc_in  input  PC_W  redirect target; bits [1:0] are dropped
- retired  output  32  count of retired instructions, wraps at 2^32

## Operation
- States:
  - FETCH: mem_rd=1, mem_addr=pc.
  - HOLD: ir_valid=1.
  - DRAIN: mem_rd=1, returned data is discarded.
- Reset values:
  - state=FETCH, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, retired=0.
  - mem_rd=1 in the first cycle after reset is released.
- FETCH with mem_ack:
  - ir<=mem_rdata, ir_pc<=pc, pc<=pc+4 (modulo 2^PC_W), go to HOLD.
- FETCH without mem_ack: stay in FETCH with mem_addr held stable.
- HOLD with ir_ready:
  - retired<=retired+1.
  - If pc_load: pc<={pc_in[PC_W-1:2],2'b00}.
  - Go to FETCH.
- HOLD without ir_ready: ir, ir_pc and ir_valid hold.
- pc_load or pc_in outside an ir_valid & ir_ready cycle: ignored.
- reset mid-transaction: abandons any outstanding request. The memory must tolerate mem_rd dropping without an ack.
- DRAIN is reachable only with IFU_PREFETCH_EN.

## Timing
- Minimum fetch latency: mem_ack in the same cycle mem_rd rises puts ir_valid=1 on the next cycle.
- Without prefetch: at most one instruction every 2 cycles, FETCH then HOLD.
- ir and ir_pc change only on the edge that ends a FETCH-with-ack cycle, or (prefetch) a retire cycle.
- mem_addr is stable for as long as mem_rd is high.

## Configuration
Macro: IFU_PREFETCH_EN. Without it, the block behaves exactly as described in Operation and DRAIN is unreachable.

With it, a one-entry prefetch buffer (pf_buf, pf_valid; reset pf_valid=0) is added:
- While in HOLD with pf_valid=0:
  - mem_rd=1 at address pc.
  - On ack: pf_buf<=mem_rdata, pf_valid<=1, pc<=pc+4.
- Retire without pc_load, pf_valid=1:
  - ir<=pf_buf, ir_pc<=pc-4, pf_valid<=0, stay in HOLD.
- Retire without pc_load, pf_valid=0, ack this same cycle:
  - ir<=mem_rdata, ir_pc<=pc, pc<=pc+4, stay in HOLD.
- Retire without pc_load, pf_valid=0, no ack:
  - Go to FETCH with the request kept asserted and the address unchanged.
- Retire with pc_load:
  - pf_valid<=0, pc<=target.
  - If a request is outstanding without ack this cycle, go to DRAIN; otherwise go to FETCH. Any ack in this cycle is discarded.
- DRAIN:
  - Hold mem_addr at the stale address until mem_ack.
  - Discard the returned data, then go to FETCH at pc.

## Test plan
- Reset, RESET_PC=0, memory acks every cycle, word at 0 = 32'h8B020020 -> cycle 1 after reset: mem_rd=1, mem_addr=0; cycle 2: ir=32'h8B020020, ir_valid=1, ir_pc=0.
- Memory ack delayed 3 cycles -> mem_addr stays 0 and mem_rd stays high for all 3 cycles; ir_valid stays 0 until the cycle after ack.
- Retire at ir_pc=0x10 with pc_load=1, pc_in=0x43 -> next mem_addr=0x40; retired increments by 1; pc_load pulsed while ir_valid=0 has no effect.
- ir_ready held low for 10 cycles -> ir, ir_pc and ir_valid are unchanged; no mem_rd while prefetch is disabled.
- IFU_PREFETCH_EN, acks immediate, sequential code -> after the first fetch, ir_valid stays high and ir_pc advances by 4 on each retire cycle.
- IFU_PREFETCH_EN, retire with pc_load while a prefetch to 0x24 is unacked -> DRAIN holds mem_addr=0x24 until ack; data is discarded; the next ir comes from the branch target.
